fetch_stage: RTL and testbench

Instruction-fetch stage plus IF/ID pipeline register of the pipelined MIPS core, directly upstream of the decode stage and the hazard unit. Holds the PC, drives the combinational instruction-memory address, and selects the next PC among sequential, branch and jump targets. Honours the hazard unit's `stallF`/`stallD`, inserts a bubble on taken control transfers, and keeps saturating performance counters.

---
 rtl/mips_pkg.sv | 13 +
 rtl/flopenrc.sv | 25 ++
 rtl/fetch_stage.sv | 87 ++++++++
 tb/tb_fetch_stage.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared constants and types for the pipelined MIPS core.
package mips_pkg;

    localparam logic [31:0] NOP              = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        PC_SEQ,
        PC_BRANCH,
        PC_JUMP
    } pc_sel_t;

endpackage

// File: rtl/flopenrc.sv
// Pipeline register with enable, synchronous clear and async active-low reset.
module flopenrc #(
    parameter int                 WIDTH     = 32,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Clear only takes effect when enabled, so a held stage is never flushed.
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q <= RESET_VAL;
        end else if (en) begin
            if (clr) q <= '0;
            else     q <= d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID register, next-PC select and saturating counters.
module fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             stallF,
    input  logic             stallD,
    input  logic             pcsrcD,
    input  logic [31:0]      pcbranchD,
    input  logic             jumpD,
    output logic [31:0]      pcF,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      instrD,
    output logic [31:0]      pcplus4D,
    output logic             validD,
    output logic [CNT_W-1:0] fetch_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] redirect_cnt
);

    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    logic [31:0] pcplus4F;
    logic [31:0] jump_target;
    logic [31:0] next_pc;
    logic        redirect;
    logic        fetch_load;
    pc_sel_t     pc_sel;

    assign pcplus4F    = pcF + 32'd4;
    assign jump_target = {pcplus4D[31:28], instrD[25:0], 2'b00};
    assign redirect    = (pcsrcD | jumpD) & ~stallD;
    assign fetch_load  = ~stallD & ~redirect;

    always_comb begin
        pc_sel = PC_SEQ;
        if (!stallD && jumpD)       pc_sel = PC_JUMP;
        else if (!stallD && pcsrcD) pc_sel = PC_BRANCH;
    end

    always_comb begin
        next_pc = pcplus4F;
        case (pc_sel)
            PC_JUMP:   next_pc = jump_target;
            PC_BRANCH: next_pc = pcbranchD & ~32'h3;
            default:   next_pc = pcplus4F;
        endcase
    end

    // A redirect overrides stallF so the target is never lost.
    flopenrc #(.WIDTH(32), .RESET_VAL(RESET_PC_ALIGNED)) pc_reg (
        .clk(clk), .reset_n(reset_n), .en(~stallF | redirect), .clr(1'b0),
        .d(next_pc), .q(pcF)
    );

    flopenrc #(.WIDTH(32), .RESET_VAL(NOP)) instr_reg (
        .clk(clk), .reset_n(reset_n), .en(~stallD), .clr(redirect),
        .d(imem_rdata), .q(instrD)
    );

    flopenrc #(.WIDTH(32), .RESET_VAL(32'h0)) pcplus4_reg (
        .clk(clk), .reset_n(reset_n), .en(~stallD), .clr(redirect),
        .d(pcplus4F), .q(pcplus4D)
    );

    flopenrc #(.WIDTH(1), .RESET_VAL(1'b0)) valid_reg (
        .clk(clk), .reset_n(reset_n), .en(~stallD), .clr(redirect),
        .d(1'b1), .q(validD)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_cnt    <= '0;
            stall_cnt    <= '0;
            redirect_cnt <= '0;
        end else begin
            if (fetch_load && (fetch_cnt != '1))  fetch_cnt    <= fetch_cnt + CNT_W'(1);
            if (stallD && (stall_cnt != '1))      stall_cnt    <= stall_cnt + CNT_W'(1);
            if (redirect && (redirect_cnt != '1)) redirect_cnt <= redirect_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a 32-bit-counter instance and a 4-bit-counter instance share stimulus.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        stallF, stallD, pcsrcD, jumpD;
    logic [31:0] pcbranchD;
    logic [31:0] imem_rdata;

    logic [31:0] pcF, instrD, pcplus4D;
    logic        validD;
    logic [31:0] fetch_cnt, stall_cnt, redirect_cnt;

    logic [31:0] pcF4, instrD4, pcplus4D4;
    logic        validD4;
    logic [3:0]  fetch_cnt4, stall_cnt4, redirect_cnt4;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] imem(input logic [31:0] addr);
        case (addr)
            32'h0000_0000: return 32'h2008_0005;
            32'h1000_0004: return 32'h0800_0010;
            default:       return addr ^ 32'hC0DE_0000;
        endcase
    endfunction

    assign imem_rdata = imem(pcF);

    fetch_stage #(.RESET_PC(32'h0), .CNT_W(32)) dut (
        .clk(clk), .reset_n(reset_n), .stallF(stallF), .stallD(stallD),
        .pcsrcD(pcsrcD), .pcbranchD(pcbranchD), .jumpD(jumpD), .pcF(pcF),
        .imem_rdata(imem_rdata), .instrD(instrD), .pcplus4D(pcplus4D),
        .validD(validD), .fetch_cnt(fetch_cnt), .stall_cnt(stall_cnt),
        .redirect_cnt(redirect_cnt)
    );

    fetch_stage #(.RESET_PC(32'h0), .CNT_W(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .stallF(stallF), .stallD(stallD),
        .pcsrcD(pcsrcD), .pcbranchD(pcbranchD), .jumpD(jumpD), .pcF(pcF4),
        .imem_rdata(imem_rdata), .instrD(instrD4), .pcplus4D(pcplus4D4),
        .validD(validD4), .fetch_cnt(fetch_cnt4), .stall_cnt(stall_cnt4),
        .redirect_cnt(redirect_cnt4)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_ifid(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                              input logic [31:0] pc4, input logic valid);
        check({tag, ".pcF"}, pcF, pc);
        check({tag, ".instrD"}, instrD, instr);
        check({tag, ".pcplus4D"}, pcplus4D, pc4);
        check({tag, ".validD"}, {31'b0, validD}, {31'b0, valid});
    endtask

    initial begin
        reset_n   = 1'b0;
        stallF    = 1'b0;
        stallD    = 1'b0;
        pcsrcD    = 1'b0;
        jumpD     = 1'b0;
        pcbranchD = 32'h0;
        #1;
        check_ifid("reset", 32'h0, 32'h0, 32'h0, 1'b0);
        check("reset.fetch_cnt", fetch_cnt, 32'h0);
        check("reset.stall_cnt", stall_cnt, 32'h0);
        check("reset.redirect_cnt", redirect_cnt, 32'h0);

        @(negedge clk);
        reset_n = 1'b1;
        step();
        check_ifid("first_fetch", 32'h4, 32'h2008_0005, 32'h4, 1'b1);
        check("first_fetch.fetch_cnt", fetch_cnt, 32'd1);

        // Branch with a misaligned target: low bits are forced to zero.
        pcsrcD = 1'b1; pcbranchD = 32'h0000_0043;
        step();
        check_ifid("branch", 32'h40, 32'h0, 32'h0, 1'b0);
        check("branch.redirect_cnt", redirect_cnt, 32'd1);
        check("branch.fetch_cnt", fetch_cnt, 32'd1);
        pcsrcD = 1'b0;
        step();
        check_ifid("branch_target", 32'h44, 32'hC0DE_0040, 32'h44, 1'b1);

        // Land on the j instruction at 0x1000_0004.
        pcsrcD = 1'b1; pcbranchD = 32'h1000_0004;
        step();
        pcsrcD = 1'b0;
        step();
        check_ifid("j_in_decode", 32'h1000_0008, 32'h0800_0010, 32'h1000_0008, 1'b1);

        // Jump and branch together: jump wins.
        jumpD = 1'b1; pcsrcD = 1'b1; pcbranchD = 32'h0000_0080;
        step();
        check_ifid("jump", 32'h1000_0040, 32'h0, 32'h0, 1'b0);
        check("jump.redirect_cnt", redirect_cnt, 32'd3);
        jumpD = 1'b0; pcsrcD = 1'b0;
        step();
        check_ifid("jump_target", 32'h1000_0044, 32'hD0DE_0040, 32'h1000_0044, 1'b1);
        check("jump_target.fetch_cnt", fetch_cnt, 32'd4);

        // Three stall cycles with a branch request that must be ignored.
        stallF = 1'b1; stallD = 1'b1; pcsrcD = 1'b1; pcbranchD = 32'h0000_0200;
        for (int i = 0; i < 3; i++) begin
            step();
            check_ifid($sformatf("stall%0d", i), 32'h1000_0044, 32'hD0DE_0040, 32'h1000_0044, 1'b1);
        end
        check("stall.stall_cnt", stall_cnt, 32'd3);
        check("stall.redirect_cnt", redirect_cnt, 32'd3);
        check("stall.fetch_cnt", fetch_cnt, 32'd4);
        stallF = 1'b0; stallD = 1'b0; pcsrcD = 1'b0;
        step();
        check_ifid("stall_release", 32'h1000_0048, 32'hD0DE_0044, 32'h1000_0048, 1'b1);

        // PC wrap from the top of the address space.
        pcsrcD = 1'b1; pcbranchD = 32'hFFFF_FFFC;
        step();
        check("wrap_redirect.pcF", pcF, 32'hFFFF_FFFC);
        pcsrcD = 1'b0;
        step();
        check_ifid("wrap", 32'h0, 32'h3F21_FFFC, 32'h0, 1'b1);
        check("wrap.fetch_cnt", fetch_cnt, 32'd6);

        // Twelve more fetches: 18 total, so the 4-bit counter saturates.
        for (int i = 0; i < 12; i++) step();
        check_ifid("seq_run", 32'h30, 32'hC0DE_002C, 32'h30, 1'b1);
        check("seq_run.fetch_cnt", fetch_cnt, 32'd18);
        check("sat.fetch_cnt4", {28'b0, fetch_cnt4}, 32'h0000_000F);
        check("sat.redirect_cnt4", {28'b0, redirect_cnt4}, 32'd4);
        check("sat.pcF4", pcF4, 32'h30);

        // Asynchronous reset in the middle of a stall.
        stallF = 1'b1; stallD = 1'b1;
        step();
        check("pre_reset.stall_cnt", stall_cnt, 32'd4);
        #2;
        reset_n = 1'b0;
        #1;
        check_ifid("async_reset", 32'h0, 32'h0, 32'h0, 1'b0);
        check("async_reset.fetch_cnt", fetch_cnt, 32'h0);
        check("async_reset.stall_cnt", stall_cnt, 32'h0);
        check("async_reset.redirect_cnt", redirect_cnt, 32'h0);
        check("async_reset.fetch_cnt4", {28'b0, fetch_cnt4}, 32'h0);

        stallF = 1'b0; stallD = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        step();
        check_ifid("refetch", 32'h4, 32'h2008_0005, 32'h4, 1'b1);
        check("refetch.fetch_cnt", fetch_cnt, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
